pipelined_add_sub: RTL and testbench

Parametrised successor to the team's 32-bit ripple adder. Performs WIDTH-bit add or subtract with carry-in. The carry chain is split into STAGES registered segments, so the long ripple path is broken for timing. A valid/ready stream interface lets the block sit between the register-file read stage and the ALU result mux, with backpressure.

---
 rtl/add_sub_pkg.sv | 17 +
 rtl/pipelined_add_sub_if.sv | 31 +++
 rtl/add_seg.sv | 23 ++
 rtl/pipelined_add_sub.sv | 131 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants and elaboration helpers for the segmented add/sub pipeline.
package add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one carry-chain segment.
    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Legal when the operand splits into equal segments of at least one bit.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result stream between register-file read and the ALU result mux.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r_add;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, data_a, data_b, carry_in, sub, out_ready,
        input  in_ready, out_valid, r_add, carry_out, overflow, zero
    );

    // The adder itself.
    modport slave (
        input  in_valid, data_a, data_b, carry_in, sub, out_ready,
        output in_ready, out_valid, r_add, carry_out, overflow, zero
    );

endinterface

// File: rtl/add_seg.sv
// One combinational slice of the carry chain.
module add_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    localparam int unsigned W1 = SEG + 1;

    logic [SEG:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + W1'(cin);
    assign sum      = full[SEG-1:0];
    assign cout     = full[SEG];
    // Carry into the slice MSB, recovered from the sum bit.
    assign c_msb_in = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// segments; the whole pipe advances or stalls as one on the output handshake.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_add_sub_if.slave bus
);

    localparam int unsigned SEG = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic             adv;
    logic             accept;
    logic             last_valid;
    logic [WIDTH-1:0] b_eff;

    // Per-slice inputs (st_*) and results (nx_*); slice k works on bits k*SEG +: SEG.
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_r    [STAGES];
    logic             st_c    [STAGES];
    logic [WIDTH-1:0] nx_r    [STAGES];
    logic             nx_c    [STAGES];
    logic             nx_m    [STAGES];
    logic [SEG-1:0]   seg_sum [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] r_add_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;

    assign adv    = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && adv;
    // B is inverted once at entry; later slices only see the skewed copy.
    assign b_eff  = (bus.sub == MODE_SUB) ? ~bus.data_b : bus.data_b;

    assign st_a[0] = bus.data_a;
    assign st_b[0] = b_eff;
    assign st_c[0] = bus.carry_in;
    assign st_r[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        add_seg #(.SEG(SEG)) u_seg (
            .a        (st_a[k][k*SEG +: SEG]),
            .b        (st_b[k][k*SEG +: SEG]),
            .cin      (st_c[k]),
            .sum      (seg_sum[k]),
            .cout     (nx_c[k]),
            .c_msb_in (nx_m[k])
        );
        // Segment k bits of st_r are still zero here, so OR merges the new slice.
        assign nx_r[k] = st_r[k] | (WIDTH'(seg_sum[k]) << (k*SEG));
    end

    if (STAGES > 1) begin : g_pipe
        logic [WIDTH-1:0]  a_q [STAGES-1];
        logic [WIDTH-1:0]  b_q [STAGES-1];
        logic [WIDTH-1:0]  r_q [STAGES-1];
        logic              c_q [STAGES-1];
        logic [STAGES-2:0] v_q;

        // Inter-stage registers: partial result, segment carry and skewed operands.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                for (int i = 0; i < int'(STAGES) - 1; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                    r_q[i] <= '0;
                    c_q[i] <= 1'b0;
                end
            end else if (adv) begin
                v_q[0] <= accept;
                for (int i = 1; i < int'(STAGES) - 1; i++) begin
                    v_q[i] <= v_q[i-1];
                end
                for (int i = 0; i < int'(STAGES) - 1; i++) begin
                    a_q[i] <= st_a[i];
                    b_q[i] <= st_b[i];
                    r_q[i] <= nx_r[i];
                    c_q[i] <= nx_c[i];
                end
            end
        end

        for (genvar k = 1; k < STAGES; k++) begin : g_link
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_r[k] = r_q[k-1];
            assign st_c[k] = c_q[k-1];
        end

        assign last_valid = v_q[STAGES-2];
    end else begin : g_flat
        assign last_valid = accept;
    end

    // Final stage: result and flags, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_add_q     <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= last_valid;
            r_add_q     <= nx_r[STAGES-1];
            carry_out_q <= nx_c[STAGES-1];
            overflow_q  <= nx_m[STAGES-1] ^ nx_c[STAGES-1];
            zero_q      <= (nx_r[STAGES-1] == '0);
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.r_add     = r_add_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and randomised checks of pipelined_add_sub at STAGES = 4, 1 and 32.
module tb_pipelined_add_sub;

    localparam int unsigned WIDTH = 32;
    localparam int          NV    = 1000;

    typedef struct packed {
        logic [31:0] r;
        logic        co;
        logic        ov;
        logic        z;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fail    = 0;

    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus4  ();
    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus1  ();
    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus32 ();

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: two's-complement add with overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic ci, input logic [31:0] cyc);
        logic [31:0] bb;
        logic [32:0] full;
        exp_t        e;
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + 33'(ci);
        e.r   = full[31:0];
        e.co  = full[32];
        e.ov  = (a[31] == bb[31]) && (e.r[31] != a[31]);
        e.z   = (e.r == 32'h0);
        e.cyc = cyc;
        return e;
    endfunction

    // Single op on the 4-stage DUT: checks latency, result and flags.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic ci, input logic [31:0] er,
                         input logic eco, input logic eov, input logic ez);
        int lat;
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.data_a    = a;
        bus4.data_b    = b;
        bus4.sub       = s;
        bus4.carry_in  = ci;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"},   64'(lat),            64'(4));
        check({tag, " r_add"},     64'(bus4.r_add),     64'(er));
        check({tag, " carry_out"}, 64'(bus4.carry_out), 64'(eco));
        check({tag, " overflow"},  64'(bus4.overflow),  64'(eov));
        check({tag, " zero"},      64'(bus4.zero),      64'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp4 [8];
        exp_t        q1  [$];
        exp_t        q32 [$];
        exp_t        e;
        exp_t        got;
        int          sent;
        int          recv;
        int          cyc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rc;

        rst = 1'b1;
        bus4.in_valid = 1'b0;  bus4.out_ready = 1'b1;
        bus4.data_a = '0;      bus4.data_b = '0;  bus4.sub = 1'b0;  bus4.carry_in = 1'b0;
        bus1.in_valid = 1'b0;  bus1.out_ready = 1'b1;
        bus1.data_a = '0;      bus1.data_b = '0;  bus1.sub = 1'b0;  bus1.carry_in = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        bus32.data_a = '0;     bus32.data_b = '0; bus32.sub = 1'b0; bus32.carry_in = 1'b0;
        #1;
        check("reset out_valid", 64'(bus4.out_valid), 64'(0));
        check("reset r_add",     64'(bus4.r_add),     64'(0));
        check("reset carry_out", 64'(bus4.carry_out), 64'(0));
        check("reset overflow",  64'(bus4.overflow),  64'(0));
        check("reset zero",      64'(bus4.zero),      64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post-reset in_ready",  64'(bus4.in_ready),  64'(1));
        check("post-reset out_valid", 64'(bus4.out_valid), 64'(0));

        do_op("t1 wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("t2 5-7",       32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("t2 7-5",       32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        do_op("t3 pos ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("t3 neg ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op("cin ripple",   32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        do_op("sub no cin",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        do_op("min+min",      32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

        // Stream of 8 with the consumer stalled in cycles 6..8.
        for (int i = 0; i < 8; i++) exp4[i] = 32'(i + 1) * 32'h0001_0002;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 8 && cyc < 40) begin
            bus4.out_ready = !(cyc >= 6 && cyc <= 8);
            bus4.in_valid  = (sent < 8);
            bus4.data_a    = 32'(sent + 1);
            bus4.data_b    = 32'(sent + 1) * 32'h0001_0001;
            bus4.sub       = 1'b0;
            bus4.carry_in  = 1'b0;
            #1;
            check($sformatf("stream in_ready c%0d", cyc), 64'(bus4.in_ready),
                  64'((cyc < 6 || cyc > 8) ? 1 : 0));
            if (bus4.out_valid) begin
                check($sformatf("stream r_add #%0d c%0d", recv, cyc), 64'(bus4.r_add), 64'(exp4[recv]));
                if (bus4.out_ready) recv++;
            end
            if (bus4.in_valid && bus4.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        check("stream count", 64'(recv), 64'(8));
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stream no extra", 64'(bus4.out_valid), 64'(0));
            @(posedge clk); #1;
        end

        // Reset with one result on the output and three ops in flight.
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.data_a   = 32'h100 + 32'(i);
            bus4.data_b   = 32'h200;
            bus4.sub      = 1'b0;
            bus4.carry_in = 1'b0;
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        check("pre-rst out_valid", 64'(bus4.out_valid), 64'(1));
        check("pre-rst r_add",     64'(bus4.r_add),     64'(32'h300));
        rst = 1'b1;
        #1;
        check("in-rst out_valid", 64'(bus4.out_valid), 64'(0));
        check("in-rst r_add",     64'(bus4.r_add),     64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no stale after rst", 64'(bus4.out_valid), 64'(0));
        end
        do_op("after rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Random stream into the 1-stage and 32-stage builds.
        for (cyc = 0; cyc < NV + 40; cyc++) begin
            if (cyc < NV) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                bus1.in_valid  = 1'b1; bus1.data_a  = ra; bus1.data_b  = rb; bus1.sub  = rs; bus1.carry_in  = rc;
                bus32.in_valid = 1'b1; bus32.data_a = ra; bus32.data_b = rb; bus32.sub = rs; bus32.carry_in = rc;
                e = model(ra, rb, rs, rc, 32'(cyc));
                q1.push_back(e);
                q32.push_back(e);
            end else begin
                bus1.in_valid  = 1'b0;
                bus32.in_valid = 1'b0;
            end
            #1;
            if (cyc < NV)
                check("rand in_ready", 64'({bus1.in_ready, bus32.in_ready}), 64'(2'b11));
            if (bus1.out_valid) begin
                check("s1 result expected", 64'(q1.size() > 0), 64'(1));
                if (q1.size() > 0) begin
                    e   = q1.pop_front();
                    got = '{r: bus1.r_add, co: bus1.carry_out, ov: bus1.overflow, z: bus1.zero, cyc: e.cyc};
                    check($sformatf("s1 data c%0d", cyc), 64'(got), 64'(e));
                    check("s1 latency", 64'(32'(cyc) - e.cyc), 64'(1));
                end
            end
            if (bus32.out_valid) begin
                check("s32 result expected", 64'(q32.size() > 0), 64'(1));
                if (q32.size() > 0) begin
                    e   = q32.pop_front();
                    got = '{r: bus32.r_add, co: bus32.carry_out, ov: bus32.overflow, z: bus32.zero, cyc: e.cyc};
                    check($sformatf("s32 data c%0d", cyc), 64'(got), 64'(e));
                    check("s32 latency", 64'(32'(cyc) - e.cyc), 64'(32));
                end
            end
            @(posedge clk); #1;
        end
        check("s1 all drained",  64'(q1.size()),  64'(0));
        check("s32 all drained", 64'(q32.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
